// File: rtl/regfile_sb_pkg.sv
// Shared types and constants for the regfile_sb register file.
// Define REGFILE_FWD_EN to enable same-cycle write-to-read forwarding.
package regfile_sb_pkg;

    typedef enum logic {
        RF_ST_INIT = 1'b0,
        RF_ST_RUN  = 1'b1
    } rf_state_e;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic        RST_ENABLE   = 1'b0;
    localparam logic        WRITE_ENABLE = 1'b1;
    localparam logic        READ_ENABLE  = 1'b1;
    localparam logic [4:0]  REG_NOP      = 5'b00000;

`ifdef REGFILE_FWD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

endpackage

// File: rtl/regfile_sb_rd_port.sv
// One register-file read port: zero/enable/forward data mux and the
// scoreboard hazard flag for the addressed source register.
module regfile_rd_port
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              i_run,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_ra,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wa,
    input  logic [DATA_W-1:0] i_wd,
    input  logic [DATA_W-1:0] i_reg_data,
    input  logic              i_busy,
    output logic [DATA_W-1:0] o_rd,
    output logic              o_rbusy
);

    logic w_src_valid;
    logic w_fwd_hit;

    // Source qualification and forward-hit detection.
    always_comb begin
        w_src_valid = i_run && (i_re == READ_ENABLE) && (i_ra != ADDR_W'(REG_NOP));
        w_fwd_hit   = FWD_EN && (i_we == WRITE_ENABLE) && (i_wa == i_ra);
    end

    // Data mux in priority order: zero register, disabled port, forward, array.
    always_comb begin
        o_rd = DATA_W'(ZERO_WORD);
        if (!w_src_valid) begin
            o_rd = DATA_W'(ZERO_WORD);
        end else if (w_fwd_hit) begin
            o_rd = i_wd;
        end else begin
            o_rd = i_reg_data;
        end
    end

    // A forwarded producer no longer counts as pending.
    always_comb begin
        o_rbusy = w_src_valid && i_busy && !w_fwd_hit;
    end

endmodule

// File: rtl/regfile_sb.sv
// MiniMIPS32 register file with post-reset clear sweep, busy scoreboard and
// optional write-to-read forwarding (enabled by defining REGFILE_FWD_EN).
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     cpu_clk_50M,
    input  logic                     cpu_rst_n,
    output logic                     init_done,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     iss_v,
    input  logic [ADDR_W-1:0]        iss_wa,
    input  logic                     flush
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    rf_state_e         r_state;
    rf_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic              r_init_done;
    logic              w_run;
    logic              w_wr_en;
    logic              w_iss_en;

    // Qualified write/issue strobes; nothing from the pipeline acts during the sweep.
    always_comb begin
        w_run    = (r_state == RF_ST_RUN);
        w_wr_en  = w_run && (we == WRITE_ENABLE) && (wa != ADDR_W'(REG_NOP));
        w_iss_en = w_run && iss_v && (iss_wa != ADDR_W'(REG_NOP));
    end

    // Sweep FSM next state: leave INIT once the last entry is being cleared.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RF_ST_INIT: begin
                if (r_clr_cnt == {ADDR_W{1'b1}}) begin
                    w_state_nxt = RF_ST_RUN;
                end else begin
                    w_state_nxt = RF_ST_INIT;
                end
            end
            RF_ST_RUN: w_state_nxt = RF_ST_RUN;
            default:   w_state_nxt = RF_ST_INIT;
        endcase
    end

    // Sweep FSM state, clear counter and init_done flag.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (cpu_rst_n == RST_ENABLE) begin
            r_state     <= RF_ST_INIT;
            r_clr_cnt   <= {ADDR_W{1'b0}};
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_done <= (w_state_nxt == RF_ST_RUN);
            if (r_state == RF_ST_INIT) begin
                r_clr_cnt <= r_clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                r_clr_cnt <= r_clr_cnt;
            end
        end
    end

    // Storage array: the sweep owns the write port until RUN; contents are never reset.
    always_ff @(posedge cpu_clk_50M) begin
        if (r_state == RF_ST_INIT) begin
            r_regs[r_clr_cnt] <= DATA_W'(ZERO_WORD);
        end else if (w_wr_en) begin
            r_regs[wa] <= wd;
        end
    end

    // Scoreboard update: flush dominates; an issue overrides a same-address writeback.
    always_comb begin
        w_busy_nxt = r_busy;
        if (!w_run) begin
            w_busy_nxt = r_busy;
        end else if (flush) begin
            w_busy_nxt = {DEPTH{1'b0}};
        end else begin
            if (w_wr_en) begin
                w_busy_nxt[wa] = 1'b0;
            end else begin
                w_busy_nxt = w_busy_nxt;
            end
            if (w_iss_en) begin
                w_busy_nxt[iss_wa] = 1'b1;
            end else begin
                w_busy_nxt = w_busy_nxt;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (cpu_rst_n == RST_ENABLE) begin
            r_busy <= {DEPTH{1'b0}};
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign init_done = r_init_done;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        assign w_ra = ra[g*ADDR_W +: ADDR_W];

        regfile_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd_port (
            .i_run      (w_run),
            .i_re       (re[g]),
            .i_ra       (w_ra),
            .i_we       (we),
            .i_wa       (wa),
            .i_wd       (wd),
            .i_reg_data (r_regs[w_ra]),
            .i_busy     (r_busy[w_ra]),
            .o_rd       (rd[g*DATA_W +: DATA_W]),
            .o_rbusy    (rbusy[g])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, randomized run
// against a behavioural model, and reset/sweep corner sequences.
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;
`ifdef REGFILE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                     cpu_clk_50M = 1'b0;
    logic                     cpu_rst_n   = 1'b0;
    logic                     init_done;
    logic                     we;
    logic [ADDR_W-1:0]        wa;
    logic [DATA_W-1:0]        wd;
    logic [NUM_RD-1:0]        re;
    logic [NUM_RD*ADDR_W-1:0] ra;
    logic [NUM_RD*DATA_W-1:0] rd;
    logic [NUM_RD-1:0]        rbusy;
    logic                     iss_v;
    logic [ADDR_W-1:0]        iss_wa;
    logic                     flush;

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst_n   (cpu_rst_n),
        .init_done   (init_done),
        .we          (we),
        .wa          (wa),
        .wd          (wd),
        .re          (re),
        .ra          (ra),
        .rd          (rd),
        .rbusy       (rbusy),
        .iss_v       (iss_v),
        .iss_wa      (iss_wa),
        .flush       (flush)
    );

    always #10 cpu_clk_50M = ~cpu_clk_50M;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  re;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        iss_v;
        logic [4:0]  iss_wa;
        logic        flush;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_rbusy;
    } vec_t;

    vec_t        tbl [15];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_regs [DEPTH];
    bit          m_busy [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input logic a_we, input logic [4:0] a_wa, input logic [31:0] a_wd,
                         input logic [1:0] a_re, input logic [4:0] a_ra0, input logic [4:0] a_ra1,
                         input logic a_iss_v, input logic [4:0] a_iss_wa, input logic a_flush);
        we = a_we; wa = a_wa; wd = a_wd; re = a_re; ra = {a_ra1, a_ra0};
        iss_v = a_iss_v; iss_wa = a_iss_wa; flush = a_flush;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] m_rd(input int p);
        logic [4:0] a;
        a = ra[p*ADDR_W +: ADDR_W];
        if (a == 5'd0 || !re[p]) return 32'h0;
        if (FWD && we && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic logic m_rbusy(input int p);
        logic [4:0] a;
        a = ra[p*ADDR_W +: ADDR_W];
        return re[p] && a != 5'd0 && m_busy[a] && !(FWD && we && wa == a);
    endfunction

    // Apply the effect of the coming clock edge to the model.
    task automatic model_commit();
        if (we && wa != 5'd0) m_regs[wa] = wd;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
        end else begin
            if (we && wa != 5'd0) m_busy[wa] = 1'b0;
            if (iss_v && iss_wa != 5'd0) m_busy[iss_wa] = 1'b1;
        end
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    // Called at a negedge right after reset release; checks the 32-cycle sweep.
    task automatic sweep_check(input string tag);
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b1, 5'd3, 32'hFFFF_FFFF, 2'b11, 5'd3, 5'd4, 1'b1, 5'd4, 1'b0);
            #1;
            chk({tag, "_sweep_init_done"}, {31'h0, init_done}, 32'h0);
            chk({tag, "_sweep_rd0"}, rd[31:0], 32'h0);
            chk({tag, "_sweep_rbusy"}, {30'h0, rbusy}, 32'h0);
            @(negedge cpu_clk_50M);
        end
        drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0);
        #1;
        chk({tag, "_init_done_high"}, {31'h0, init_done}, 32'h1);
        chk({tag, "_post_sweep_rd0"}, rd[31:0], 32'h0);
        chk({tag, "_post_sweep_rbusy"}, {30'h0, rbusy}, 32'h0);
        model_clear();
        @(negedge cpu_clk_50M);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 5'd7,  32'h1234_5678, 2'b11, 5'd7,  5'd0, 1'b0, 5'd0, 1'b0,
                    FWD ? 32'h1234_5678 : 32'h0, 32'h0, 2'b00};
        tbl[1]  = '{1'b0, 5'd0,  32'h0, 2'b11, 5'd7,  5'd0, 1'b0, 5'd0, 1'b0, 32'h1234_5678, 32'h0, 2'b00};
        tbl[2]  = '{1'b0, 5'd0,  32'h0, 2'b01, 5'd9,  5'd0, 1'b1, 5'd9, 1'b0, 32'h0, 32'h0, 2'b00};
        tbl[3]  = '{1'b0, 5'd0,  32'h0, 2'b01, 5'd9,  5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 2'b01};
        tbl[4]  = '{1'b1, 5'd9,  32'hAAAA_0009, 2'b01, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0,
                    FWD ? 32'hAAAA_0009 : 32'h0, 32'h0, FWD ? 2'b00 : 2'b01};
        tbl[5]  = '{1'b0, 5'd0,  32'h0, 2'b01, 5'd9,  5'd0, 1'b0, 5'd0, 1'b0, 32'hAAAA_0009, 32'h0, 2'b00};
        tbl[6]  = '{1'b1, 5'd5,  32'h0000_0055, 2'b01, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0,
                    FWD ? 32'h0000_0055 : 32'h0, 32'h0, 2'b00};
        tbl[7]  = '{1'b0, 5'd0,  32'h0, 2'b11, 5'd5,  5'd9, 1'b1, 5'd6, 1'b0, 32'h55, 32'hAAAA_0009, 2'b01};
        tbl[8]  = '{1'b1, 5'd10, 32'h0000_0A0A, 2'b11, 5'd5, 5'd6, 1'b1, 5'd6, 1'b1, 32'h55, 32'h0, 2'b11};
        tbl[9]  = '{1'b0, 5'd0,  32'h0, 2'b11, 5'd5,  5'd6, 1'b0, 5'd0, 1'b0, 32'h55, 32'h0, 2'b00};
        tbl[10] = '{1'b0, 5'd0,  32'h0, 2'b01, 5'd10, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0A0A, 32'h0, 2'b00};
        tbl[11] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 32'h0, 32'h0, 2'b00};
        tbl[12] = '{1'b0, 5'd0,  32'h0, 2'b11, 5'd0,  5'd7, 1'b0, 5'd0, 1'b0, 32'h0, 32'h1234_5678, 2'b00};
        tbl[13] = '{1'b0, 5'd0,  32'h0, 2'b00, 5'd7,  5'd9, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0, 2'b00};
        tbl[14] = '{1'b0, 5'd0,  32'h0, 2'b10, 5'd3,  5'd3, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 2'b10};

        drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        model_clear();
        repeat (3) @(negedge cpu_clk_50M);
        #1;
        chk("reset_init_done", {31'h0, init_done}, 32'h0);
        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;
        sweep_check("boot");

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra0, tbl[i].ra1,
                  tbl[i].iss_v, tbl[i].iss_wa, tbl[i].flush);
            #1;
            chk($sformatf("vec%0d_rd0", i), rd[31:0], tbl[i].e_rd0);
            chk($sformatf("vec%0d_rd1", i), rd[63:32], tbl[i].e_rd1);
            chk($sformatf("vec%0d_rbusy", i), {30'h0, rbusy}, {30'h0, tbl[i].e_rbusy});
            model_commit();
            @(negedge cpu_clk_50M);
        end

        for (int i = 0; i < 400; i++) begin
            begin
                logic [4:0] w_a;
                logic [4:0] r0;
                logic [4:0] r1;
                w_a = rnd_addr();
                r0  = ($urandom_range(0, 2) == 0) ? w_a : rnd_addr();
                r1  = rnd_addr();
                drive(1'($urandom_range(0, 1)), w_a, $urandom, 2'($urandom_range(0, 3)), r0, r1,
                      1'($urandom_range(0, 1)), rnd_addr(), ($urandom_range(0, 15) == 0));
            end
            #1;
            chk($sformatf("rnd%0d_rd0", i), rd[31:0], m_rd(0));
            chk($sformatf("rnd%0d_rd1", i), rd[63:32], m_rd(1));
            chk($sformatf("rnd%0d_rbusy", i), {30'h0, rbusy}, {30'h0, m_rbusy(1), m_rbusy(0)});
            model_commit();
            @(negedge cpu_clk_50M);
        end

        // Make register 12 busy and nonzero, then reset asynchronously from RUN.
        drive(1'b1, 5'd12, 32'h0C0C_0C0C, 2'b00, 5'd0, 5'd0, 1'b1, 5'd12, 1'b0);
        @(negedge cpu_clk_50M);
        drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd12, 5'd12, 1'b0, 5'd0, 1'b0);
        #1;
        chk("pre_reset_rbusy", {30'h0, rbusy}, 32'h3);
        chk("pre_reset_rd0", rd[31:0], 32'h0C0C_0C0C);
        #3;
        cpu_rst_n = 1'b0;
        #1;
        chk("async_reset_init_done", {31'h0, init_done}, 32'h0);
        chk("async_reset_rbusy", {30'h0, rbusy}, 32'h0);
        chk("async_reset_rd0", rd[31:0], 32'h0);

        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;
        drive(1'b1, 5'd3, 32'hFFFF_FFFF, 2'b11, 5'd12, 5'd3, 1'b1, 5'd4, 1'b0);
        repeat (10) @(negedge cpu_clk_50M);
        #5;
        cpu_rst_n = 1'b0;
        #1;
        chk("midsweep_reset_init_done", {31'h0, init_done}, 32'h0);
        chk("midsweep_reset_rbusy", {30'h0, rbusy}, 32'h0);
        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;
        sweep_check("restart");

        for (int a = 1; a < DEPTH; a++) begin
            drive(1'b0, 5'd0, 32'h0, 2'b11, 5'(a), 5'(DEPTH - a), 1'b0, 5'd0, 1'b0);
            #1;
            chk($sformatf("cleared_rd0_r%0d", a), rd[31:0], m_rd(0));
            chk($sformatf("cleared_rbusy_r%0d", a), {30'h0, rbusy}, 32'h0);
            @(negedge cpu_clk_50M);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised, multi-read-port general-purpose register file for the MiniMIPS32 decode stage.
- Adds a post-reset hardware clear sequence that sweeps every entry to zero and raises init_done.
- Adds a per-register busy scoreboard: set at issue, cleared at writeback, bulk-cleared on flush.
- Adds write-to-read forwarding that is qualified by write-enable.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; depth = 2**ADDR_W; entry 0 is hard-wired to zero.
- NUM_RD, 2: number of read ports, at least 1.

Ports:
- cpu_clk_50M, in, 1: clock, rising edge.
- cpu_rst_n, in, 1: reset, asynchronous and active-low.
- init_done, out, 1: high once the clear sweep has completed.
- we, in, 1: write enable.
- wa, in, ADDR_W: write address.
- wd, in, DATA_W: write data.
- re, in, NUM_RD: per-port read enable.
- ra, in, NUM_RD*ADDR_W: read addresses, port i at bits [i*ADDR_W +: ADDR_W].
- rd, out, NUM_RD*DATA_W: read data, port i at bits [i*DATA_W +: DATA_W].
- rbusy, out, NUM_RD: port i source has a pending, unforwarded producer.
- iss_v, in, 1: issue valid; marks iss_wa as busy.
- iss_wa, in, ADDR_W: destination register of the issued instruction.
- flush, in, 1: clear all busy bits.

Behaviour:
- Reset (cpu_rst_n low, asynchronous, any time including mid-sweep):
  - state := INIT, clr_cnt := 0, all busy := 0, init_done := 0.
  - Array contents are not reset directly; the sweep zeroes them.
- INIT state, one entry per cycle:
  - Each cycle regs[clr_cnt] <= 0 and clr_cnt increments.
  - After entry 2**ADDR_W-1 is cleared, state := RUN; init_done goes high the following cycle.
  - Sweep length: exactly 2**ADDR_W cycles (32 by default).
  - During INIT: we, iss_v and flush are ignored; all rd = 0, all rbusy = 0.
- RUN state, write:
  - At posedge, if we && wa != 0 then regs[wa] <= wd.
  - Writes to wa = 0 are discarded.
- RUN state, read port i (combinational), in priority order:
  - ra_i == 0 -> rd_i = 0.
  - else re_i == 0 -> rd_i = 0.
  - else we && wa == ra_i -> rd_i = wd (forward).
  - else rd_i = regs[ra_i].
- Scoreboard, evaluated per posedge in RUN:
  - flush: all busy := 0. flush beats a same-cycle issue; a same-cycle write still lands in the array.
  - Otherwise, iss_v && iss_wa != 0 sets busy[iss_wa].
  - we && wa != 0 clears busy[wa].
  - Same address set and cleared in the same cycle: set wins (newer producer).
  - Issuing to an already-busy register is legal; the first writeback clears it (single-outstanding-producer rule, enforced upstream).
  - busy[0] is always 0.
- rbusy_i = re_i && ra_i != 0 && busy[ra_i] && !(we && wa == ra_i).
- Latency: read is 0 cycles (combinational); a write is visible in the array 1 cycle later and on the forward path in the same cycle.

Optional Feature:
- REGFILE_FWD_EN defined:
  - Forward path active as described above.
  - rbusy is masked by a matching write.
- REGFILE_FWD_EN undefined:
  - rd_i reads regs[ra_i] only, so a same-cycle write is seen next cycle.
  - rbusy is not masked by a matching write: rbusy_i = re_i && ra_i != 0 && busy[ra_i].

Decomposition:
- defines.v additions:
  - RF_ST_INIT / RF_ST_RUN state encodings (1 bit).
  - Reuse existing ZERO_WORD, RST_ENABLE, WRITE_ENABLE, READ_ENABLE, REG_NOP.
- One sub-module, regfile_rd_port:
  - Implements the per-port zero/enable/forward mux and the rbusy term.
  - Instantiated NUM_RD times via generate.
- Array, sweep FSM and scoreboard stay in the top level.

Test Plan:
- Release reset; in each sweep cycle drive we=1, wa=3, wd=0xFFFF_FFFF and iss_v=1, iss_wa=4 -> init_done=0 for 32 cycles then 1; after init_done=1, ra0=3 with re0=1 reads 0 and rbusy0=0.
- RUN, we=1, wa=7, wd=0x1234_5678, ra0=7, re0=1 -> rd0=0x1234_5678 in the same cycle with FWD_EN; without FWD_EN, old value then new value the next cycle. ra1=0 -> rd1=0 always.
- iss_v=1, iss_wa=9; next cycle ra0=9 -> rbusy0=1. Then we=1, wa=9 -> rbusy0=0 that cycle (FWD_EN) and busy[9]=0 after the edge.
- Same cycle iss_v=1, iss_wa=5 and we=1, wa=5 -> busy[5]=1 after the edge. Then flush=1 with iss_v=1, iss_wa=6 -> all busy=0.
- we=1, wa=0, wd=0xDEAD_BEEF -> ra0=0 reads 0; iss_v=1, iss_wa=0 -> rbusy never set.
- Pull cpu_rst_n low mid-sweep (clr_cnt=10) -> init_done=0 and busy=0 immediately; on release a full 32-cycle sweep restarts from entry 0.
